// File: rtl/mfrc_pkg.sv
// mfrc_pkg: shared state encodings, register map and reset values for the MFRC522-style SPI target
package mfrc_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RD_DATA, WR_DATA} state_t;
  localparam logic [5:0] REG_COMMAND   = 6'h01;
  localparam logic [5:0] REG_TXCONTROL = 6'h14;
  localparam logic [5:0] REG_VERSION   = 6'h37;
  localparam logic [7:0] RST_COMMAND   = 8'h20;
  localparam logic [7:0] RST_TXCONTROL = 8'h80;
  localparam int RD_FLAG_BIT = 7;
  function automatic logic [7:0] reset_value(input logic [5:0] a);
    return a == REG_COMMAND ? RST_COMMAND : a == REG_TXCONTROL ? RST_TXCONTROL : 8'h00;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser with rise/fall pulses on the synchronised level
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk_25mhz or posedge rst)
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/mfrc_spi_target.sv
// mfrc_spi_target: SPI mode 0 target with MFRC522 register framing over a 64x8 register file
module mfrc_spi_target
  import mfrc_pkg::*;
#(
  parameter logic [7:0] VERSION_VALUE = 8'h92,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [5:0] rd_addr,
  output logic       frame_active,
  output logic       frame_error
);
  state_t state, state_d;
  logic cs_q, cs_rise, cs_fall, sclk_q, sclk_rise, sclk_fall, mosi_q;
  logic active, byte_done, wr_en;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, rx_next, rd_val;
  logic [5:0] frame_addr, rx_addr;
  logic [7:0] regs [64];

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_25mhz(clk_25mhz), .rst(rst), .d(spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_25mhz(clk_25mhz), .rst(rst), .d(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk_25mhz or posedge rst)
    if (rst) mosi_sync <= '0;
    else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};

  assign mosi_q = mosi_sync[SYNC_STAGES-1];
  assign active = ~cs_q && state != IDLE;
  assign rx_next = {rx_shift, mosi_q};
  assign rx_addr = rx_next[6:1];
  assign byte_done = active && sclk_rise && bit_cnt == 3'd7;
  assign wr_en = byte_done && state == WR_DATA && frame_addr != REG_VERSION;
  assign rd_val = rx_addr == REG_VERSION ? VERSION_VALUE : regs[rx_addr];
  assign frame_active = ~cs_q;
  assign spi_miso_oe = ~cs_q;
  assign spi_miso = ~cs_q & tx_shift[7];

  always_ff @(posedge clk_25mhz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    if (cs_rise) state_d = IDLE;
    else if (cs_fall) state_d = ADDR;
    else if (byte_done && state == ADDR) state_d = rx_next[RD_FLAG_BIT] ? RD_DATA : WR_DATA;
  end

  always_ff @(posedge clk_25mhz or posedge rst)
    if (rst) begin
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      frame_addr <= '0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_valid <= 1'b0;
      rd_addr <= '0;
      frame_error <= 1'b0;
    end else begin
      wr_valid <= wr_en;
      rd_valid <= 1'b0;
      frame_error <= cs_rise && bit_cnt != 3'd0;
      if (wr_en) begin
        wr_addr <= frame_addr;
        wr_data <= rx_next;
      end
      if (cs_rise || cs_fall) begin
        bit_cnt <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else if (active && sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_shift <= rx_next[6:0];
        if (bit_cnt == 3'd7) begin
          tx_shift <= 8'h00;
          if (state == ADDR) frame_addr <= rx_addr;
          // every completed byte with the read flag set is a burst lookup
          if (state != WR_DATA && rx_next[RD_FLAG_BIT]) begin
            rd_valid <= 1'b1;
            rd_addr <= rx_addr;
            tx_shift <= rd_val;
          end
        end
      end else if (active && sclk_fall && !sclk_q && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end

  always_ff @(posedge clk_25mhz or posedge rst)
    if (rst) for (int i = 0; i < 64; i++) regs[i] <= reset_value(6'(i));
    else if (wr_en) regs[frame_addr] <= rx_next;
endmodule

// File: tb/tb_mfrc_spi_target.sv
// tb_mfrc_spi_target: directed and random SPI frames checked against a register-map model
module tb_mfrc_spi_target;
  localparam int HALF = 8;
  localparam logic [7:0] VER = 8'h92;
  logic clk_25mhz = 1'b0, rst = 1'b1, spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, wr_valid, rd_valid, frame_active, frame_error;
  logic [5:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  int checks = 0, passed = 0, fails = 0, ferr = 0, overlap = 0;
  logic [13:0] wr_log [$];
  logic [5:0] rd_log [$];
  logic [7:0] model [64];
  logic [7:0] fb [8];
  logic [7:0] frx [8];
  int fn;

  mfrc_spi_target dut (
    .clk_25mhz(clk_25mhz), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_addr(rd_addr), .frame_active(frame_active),
    .frame_error(frame_error)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(negedge clk_25mhz) begin
    if (wr_valid) wr_log.push_back({wr_addr, wr_data});
    if (rd_valid) rd_log.push_back(rd_addr);
    if (frame_error) ferr++;
    if (wr_valid && rd_valid) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = i == 1 ? 8'h20 : i == 20 ? 8'h80 : 8'h00;
  endtask

  function automatic logic [7:0] mread(input logic [5:0] a);
    return a == 6'h37 ? VER : model[a];
  endfunction

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk_25mhz);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_25mhz);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag);
    logic [7:0] exp_miso [8];
    logic [13:0] exp_wr [$];
    logic [5:0] exp_rd [$];
    logic rd;
    int w0, r0, f0, o0;
    rd = fb[0][7];
    exp_miso[0] = 8'h00;
    for (int k = 0; k < fn; k++) begin
      if (k > 0) exp_miso[k] = (rd && fb[k-1][7]) ? mread(fb[k-1][6:1]) : 8'h00;
      if (rd && fb[k][7]) exp_rd.push_back(fb[k][6:1]);
      if (!rd && k > 0 && fb[0][6:1] != 6'h37) exp_wr.push_back({fb[0][6:1], fb[k]});
    end
    foreach (exp_wr[i]) model[exp_wr[i][13:8]] = exp_wr[i][7:0];
    w0 = wr_log.size(); r0 = rd_log.size(); f0 = ferr; o0 = overlap;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk_25mhz);
    check({tag, " oe/active"}, {spi_miso_oe, frame_active}, 2'b11);
    for (int k = 0; k < fn; k++) xfer(fb[k], 8, frx[k]);
    repeat (HALF) @(negedge clk_25mhz);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk_25mhz);
    check({tag, " idle miso/oe"}, {spi_miso, spi_miso_oe, frame_active}, 3'b000);
    for (int k = 0; k < fn; k++) check($sformatf("%s miso%0d", tag, k), frx[k], exp_miso[k]);
    check({tag, " wr count"}, wr_log.size() - w0, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && w0 + i < wr_log.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wr_log[w0+i], exp_wr[i]);
    check({tag, " rd count"}, rd_log.size() - r0, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && r0 + i < rd_log.size(); i++)
      check($sformatf("%s rd%0d", tag, i), rd_log[r0+i], exp_rd[i]);
    check({tag, " frame_error"}, ferr - f0, 0);
    check({tag, " wr/rd overlap"}, overlap - o0, 0);
  endtask

  initial begin
    int f0, w0;
    logic [7:0] rx;
    model_reset();
    repeat (4) @(negedge clk_25mhz);
    check("reset outputs", {spi_miso, spi_miso_oe, wr_valid, rd_valid, frame_active, frame_error}, 6'b0);
    check("reset buses", {wr_addr, wr_data, rd_addr}, 20'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk_25mhz);
    check("post-reset outputs", {spi_miso, spi_miso_oe, frame_active, frame_error}, 4'b0);

    fb = '{8'h82, 8'hA8, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 4;
    run_frame("burst");
    check("burst bytes", {frx[0], frx[1], frx[2], frx[3]}, 32'h00208092);

    fb = '{8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("version");
    check("version byte", frx[1], 8'h92);

    fb = '{8'h28, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("write14");
    fb = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("read14");
    check("read14 byte", frx[1], 8'h83);

    fb = '{8'h28, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 3;
    run_frame("rewrite14");
    fb = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("reread14");
    check("reread14 byte", frx[1], 8'h02);

    fb = '{8'h6E, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("write37");
    fb = '{8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("version2");
    check("version2 byte", frx[1], 8'h92);

    f0 = ferr; w0 = wr_log.size();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk_25mhz);
    xfer(8'h28, 8, rx);
    xfer(8'hFF, 5, rx);
    repeat (HALF) @(negedge clk_25mhz);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk_25mhz);
    check("abort frame_error", ferr - f0, 1);
    check("abort wr count", wr_log.size() - w0, 0);
    fb = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("after abort");
    check("after abort byte", frx[1], 8'h02);

    f0 = ferr; w0 = wr_log.size();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk_25mhz);
    xfer(8'h28, 8, rx);
    xfer(8'h55, 4, rx);
    rst = 1'b1;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk_25mhz);
    check("mid-reset oe/miso", {spi_miso_oe, spi_miso, frame_active}, 3'b000);
    rst = 1'b0;
    repeat (2 * HALF) @(negedge clk_25mhz);
    check("mid-reset wr count", wr_log.size() - w0, 0);
    check("mid-reset frame_error", ferr - f0, 0);
    check("mid-reset oe", spi_miso_oe, 1'b0);
    model_reset();
    fb = '{8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("post-reset version");
    check("post-reset version byte", frx[1], 8'h92);
    fb = '{8'hA8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; fn = 2;
    run_frame("post-reset read14");
    check("post-reset read14 byte", frx[1], 8'h80);

    for (int f = 0; f < 24; f++) begin
      fn = $urandom_range(2, 5);
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      run_frame($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mfrc_spi_target.md
MFRC_SPI_TARGET -- requirements
Module: mfrc_spi_target

Interface
REQ-001 SHALL have parameter VERSION_VALUE, default 8'h92: read-only value returned for register 0x37.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on spi_sclk, spi_cs_n and spi_mosi.
REQ-003 SHALL have port clk_25mhz, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have ports spi_sclk, spi_cs_n and spi_mosi, each input, 1 bit: SPI mode 0 bus from the initiator, with spi_cs_n active-low.
REQ-006 SHALL have port spi_miso, output, 1 bit: serial data to the initiator, MSB first.
REQ-007 SHALL have port spi_miso_oe, output, 1 bit: MISO drive enable, high while the frame is active.
REQ-008 SHALL have ports wr_valid (output, 1), wr_addr (output, 6) and wr_data (output, 8): one-cycle pulse per committed register write.
REQ-009 SHALL have ports rd_valid (output, 1) and rd_addr (output, 6): one-cycle pulse per register read lookup.
REQ-010 SHALL have port frame_active, output, 1 bit: synchronised spi_cs_n is low.
REQ-011 SHALL have port frame_error, output, 1 bit: one-cycle pulse when CS rises mid-byte.

Function
REQ-012 SHALL sample inputs through SYNC_STAGES flip-flops and detect SCLK edges, CS falls and CS rises from the synchronised signals; the supported SCLK is at most clk_25mhz/8.
REQ-013 SHALL shift MOSI into rx_shift, MSB first, on each detected SCLK rising edge, with bit_cnt counting 0..7 and wrapping.
REQ-014 SHALL decode the first byte of a frame as follows: bit7 = 1 means read, 0 means write; bits6:1 are the register address; bit0 is ignored.
REQ-015 SHALL use state machine states IDLE, ADDR, RD_DATA and WR_DATA.
REQ-016 SHALL move from IDLE to ADDR on CS fall.
REQ-017 SHALL move, on completion of byte 0, to RD_DATA when bit7 = 1 and to WR_DATA when bit7 = 0.
REQ-018 SHALL move from any state to IDLE on CS rise.
REQ-019 SHALL, in RD_DATA, load the register value at the address decoded from each completed byte and send it as the following MISO byte; each completed MOSI byte is a new read address (MFRC522 burst semantics); rd_valid pulses with rd_addr for each lookup.
REQ-020 SHALL, in WR_DATA, write each completed byte to the frame address from byte 0 and pulse wr_valid; repeated data bytes rewrite the same address.
REQ-021 SHALL hold an internal 64x8 register file.
REQ-022 SHALL return VERSION_VALUE for address 0x37; writes to 0x37 are discarded and do not pulse wr_valid.
REQ-023 SHALL drive spi_miso from tx_shift[7] at CS fall and shift tx_shift on each detected SCLK falling edge.
REQ-024 SHALL send byte 0 of MISO as 0x00, and send 0x00 for all MISO bytes of a write frame.
REQ-025 SHALL load tx_shift on the 8th rising edge of a byte, so the next byte's MSB appears on the following falling edge.
REQ-026 SHALL hold spi_miso at 0 with spi_miso_oe = 0 while CS is high.
REQ-027 SHALL, when CS rises with bit_cnt != 0, pulse frame_error, discard the partial byte and perform no write.
REQ-028 SHALL, when CS falls during a pending CS rise, process the rise first, so frame_error and the return to IDLE occur before the new frame starts.
REQ-029 SHALL ensure wr_valid and rd_valid never assert in the same cycle.
REQ-030 SHALL ignore SCLK edges while CS is high.

Reset
REQ-031 SHALL, on rst, set the FSM to IDLE and clear bit_cnt, rx_shift and tx_shift to 0.
REQ-032 SHALL, on rst, set spi_miso, spi_miso_oe, wr_valid, rd_valid, frame_active and frame_error to 0, and wr_addr, wr_data and rd_addr to 0.
REQ-033 SHALL, on rst, preset synchroniser stages to the idle bus levels: spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0.
REQ-034 SHALL, on rst, reset the register file as follows: 0x01 = 0x20, 0x14 = 0x80, all others 0x00.
REQ-035 SHALL, when reset is applied mid-frame, abort the frame without a write; the frame resumes only after a fresh CS fall.

Structure
REQ-036 SHALL place FSM state encodings, register addresses (REG_COMMAND 0x01, REG_TXCONTROL 0x14, REG_VERSION 0x37), reset values and the read-flag bit position in shared package mfrc_pkg.
REQ-037 SHALL instantiate sub-module spi_sync_edge (N-stage synchroniser plus rise/fall pulse outputs) for SCLK and for CS.

Verification
REQ-038 SHALL verify: MOSI EE 00 -> MISO 00 92; one rd_valid with rd_addr = 0x37; no wr_valid.
REQ-039 SHALL verify: MOSI 28 83 -> wr_valid pulse with wr_addr = 0x14, wr_data = 0x83; a following read A8 00 -> MISO 00 83.
REQ-040 SHALL verify: after reset, MOSI 82 A8 EE 00 -> MISO 00 20 80 92.
REQ-041 SHALL verify: MOSI 28 01 02 -> two wr_valid pulses with data 0x01 then 0x02; a following read of 0x14 -> 0x02.
REQ-042 SHALL verify: MOSI 28 then 5 bits of 0xFF followed by CS high -> one frame_error pulse, no wr_valid, and 0x14 unchanged.
REQ-043 SHALL verify: rst asserted during byte 1 of write 28 55 -> no wr_valid, 0x14 = 0x80, spi_miso_oe = 0; the next frame EE 00 -> 00 92.
